// File: rtl/mousetrap_sync_sink.sv
// Clocked tail of a MouseTrap two-phase pipeline: synchronizes req_in, captures the bundled word into a FWFT FIFO, toggles ack_in.
// Optional MT_SINK_SYNC3_EN selects a 3-flop request synchronizer instead of the default 2-flop chain.
module mousetrap_sync_sink #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_in,
    input  logic [WORD_WIDTH-1:0]   Data_in,
    output logic                    ack_in,
    output logic [WORD_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [$clog2(DEPTH):0]  count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  req_s1;
    logic                  req_s2;
    logic                  req_sync;
    logic                  pend;
    logic                  pop;
    logic                  cap;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_nxt;
    logic [WORD_WIDTH-1:0] head_nxt;
    logic [WORD_WIDTH-1:0] mem [DEPTH];

`ifdef MT_SINK_SYNC3_EN
    logic req_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
            req_s3 <= 1'b0;
        end else begin
            req_s1 <= req_in;
            req_s2 <= req_s1;
            req_s3 <= req_s2;
        end
    end

    assign req_sync = req_s3;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
        end else begin
            req_s1 <= req_in;
            req_s2 <= req_s1;
        end
    end

    assign req_sync = req_s2;
`endif

    // Handshake: a word moves to the consumer on any edge where valid_out && ready_in;
    // valid_out never depends on ready_in, and data_out holds while valid_out && !ready_in.
    assign pend = (req_sync != ack_in);
    assign pop  = valid_out && ready_in;
    assign cap  = pend && ((count_out < CNT_W'(DEPTH)) || pop);

    always_comb begin
        count_nxt = count_out;
        case ({cap, pop})
            2'b10:   count_nxt = count_out + CNT_W'(1);
            2'b01:   count_nxt = count_out - CNT_W'(1);
            default: count_nxt = count_out;
        endcase
    end

    // The head register is preloaded with whatever will sit at the read pointer after this edge,
    // so data_out is a plain flop and an empty FIFO keeps showing the last popped word.
    always_comb begin
        head_nxt = data_out;
        if (pop) begin
            if (count_out == CNT_W'(1)) begin
                if (cap) begin
                    head_nxt = Data_in;
                end
            end else begin
                head_nxt = mem[rd_ptr + PTR_W'(1)];
            end
        end else if ((count_out == '0) && cap) begin
            head_nxt = Data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            mem[wr_ptr] <= Data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_in    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_out <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            ack_in    <= ack_in ^ cap;
            if (cap) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_out <= count_nxt;
            valid_out <= (count_nxt != '0);
            data_out  <= head_nxt;
        end
    end

endmodule

// File: doc/mousetrap_sync_sink.md
# mousetrap_sync_sink

Clocked receiver at the tail of the asynchronous MouseTrap pipeline: consumes two-phase bundled-data tokens (`req_in`/`Data_in`/`ack_in`) from the last pipeline stage and delivers them to synchronous logic through a valid/ready FIFO interface. It synchronizes the request phase into the clock domain, captures the bundled word, and toggles the acknowledge to release the upstream stage. Upstream back-pressure comes from withholding `ack_in` while the FIFO is full.

## Interface
- `WORD_WIDTH`, 32, data word width.
- `DEPTH`, 4, FIFO entries; power of two, >= 2.
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; release is synchronized externally.
- `req_in`  in  1  two-phase request from the upstream stage; each transition is one token.
- `Data_in`  in  WORD_WIDTH  bundled data; stable from a `req_in` transition until the matching `ack_in` transition.
- `ack_in`  out  1  two-phase acknowledge to upstream; registered.
- `data_out`  out  WORD_WIDTH  FIFO head (first-word fall-through).
- `valid_out`  out  1  FIFO non-empty.
- `ready_in`  in  1  consumer accepts `data_out` when `valid_out && ready_in`.
- `count_out`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- **Synchronizer:** `req_in` passes through a 2-flop chain `req_s1` -> `req_s2`. Reset value is 0.
- **Pending token:** `pend = (req_s2 != ack_in)`. Phase comparison only; level values carry no meaning.
- **Pop:** `pop = valid_out && ready_in`.
- **Capture:** `cap = pend && (count < DEPTH || pop)`.
  - On `cap`: write `Data_in` at the write pointer and toggle `ack_in`.
  - After the toggle, `req_s2 == ack_in`, so a token is never captured twice.
- **Bundling constraint:** the synchronizer delay of at least 2 clocks is the bundling margin. `Data_in` is guaranteed settled when `pend` is seen.
- **Full:** `pend` held, no capture, `ack_in` unchanged. The upstream stage stays opaque and the pipeline stalls.
- **Empty:** `valid_out = 0`, and `data_out` holds the last popped value.
- **Simultaneous `cap` and `pop`:**
  - Count is unchanged and both pointers advance.
  - This is allowed at full (the write lands on the slot being freed) and at `count = 1`.
  - At `count = 0`, `pop` is impossible, so `cap` alone makes count 1.
- **Pointers:** `$clog2(DEPTH)` bits, wrap naturally modulo DEPTH. Count is tracked separately, so full and empty are unambiguous.
- **Reset values (asynchronous, any time):**
  - `ack_in = 0`, `valid_out = 0`, `count_out = 0`, `data_out = 0`.
  - Pointers 0, synchronizer 0; FIFO contents need not be reset.
  - Reset mid-operation discards stored and in-flight tokens. The upstream pipeline must be reset concurrently so that `req_in = 0`.
  - If `req_in = 1` at reset release, it is treated as one pending token and captured after the synchronizer latency.

## Timing
- **Latency:** a `req_in` transition before edge N gives `req_s2` at edge N+1, and capture plus `ack_in` toggle at edge N+2. `valid_out` and `data_out` are valid after edge N+2.
  - Metastability can add 1 cycle.
- **Throughput:** at most one token per 2 clocks upstream-limited, since each new `req_in` phase needs the synchronizer. At most one token per cycle downstream.
- **Output timing:** `ack_in`, `valid_out` and `count_out` are registered. `data_out` is a registered array read at the read pointer, with no combinational path from `ready_in`.
- **Back-pressure:** `ack_in` toggles in the same edge that a slot frees if `pend` was already set.

## Configuration
- Macro `MT_SINK_SYNC3_EN`.
- **Defined:** 3-flop synchronizer `req_s1` -> `req_s2` -> `req_s3`, and `pend` uses `req_s3`. Latency to capture becomes N+3; all other behaviour is identical.
- **Undefined:** 2-flop synchronizer as described above.

## Test plan
- **Reset:** assert `rst_n = 0` with `req_in = 0` -> `ack_in = 0`, `valid_out = 0`, `count_out = 0`, held until release.
- **Single token:** toggle `req_in` 0->1 with `Data_in = 32'hA5A5_0001`, `ready_in = 0` -> `ack_in` goes 1 two edges later, `valid_out = 1`, `data_out = 32'hA5A5_0001`, `count_out = 1`.
- **Fill and stall:** 5 tokens `32'h1`..`32'h5`, `DEPTH = 4`, `ready_in = 0` -> `count_out = 4` and `ack_in` toggled 4 times. The fifth `req_in` phase stays unacknowledged.
  - Then raise `ready_in` for 1 cycle -> the pop of `32'h1` and capture of `32'h5` happen in the same edge, and `count_out` stays 4.
- **Drain order:** from the full state, `ready_in = 1` continuously -> `data_out` sequence `2`,`3`,`4`,`5`, then `valid_out = 0` and `count_out = 0`. The pointers wrap past index 3.
- **Streaming:** 16 back-to-back tokens with `ready_in = 1` -> all 16 received in order, `count_out <= 1`, no duplicate and no dropped word.
- **Reset mid-stream:** apply `rst_n = 0` with `count_out = 3` while a token is pending -> all outputs return to reset values immediately. After release with `req_in = 0`, no phantom token appears.
